// File: rtl/uart_transmitter.sv
// 8N1 serial transmitter with a one-byte holding buffer.
// A held byte follows the current frame with no idle gap on the line.
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          accept;
   logic          bit_end;
   logic          reload;

   assign o_ready = !hold_full_q && !i_rst;
   assign accept  = i_valid && o_ready;
   assign bit_end = (cnt_q == LAST);
   assign reload  = (state_q == STOP) && bit_end;

   always_comb begin
      state_d     = state_q;
      cnt_d       = bit_end ? '0 : cnt_q + 1'b1;
      idx_d       = idx_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_d        = tx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               state_d = START;
               shift_d = i_data;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[1];
               end
            end
         end
         STOP: begin
            // pulse is registered, so raise it one cycle ahead
            done_d = (cnt_q == PRE);
            if (bit_end) begin
               if (hold_full_q) begin
                  state_d     = START;
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
                  tx_d        = 1'b0;
               end else if (accept) begin
                  state_d = START;
                  shift_d = i_data;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (accept && (state_q != IDLE) && !reload) begin
         hold_d      = i_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign o_tx   = tx_q;
   assign o_busy = busy_q;
   assign o_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-position reference model,
// directed scenarios plus random traffic at two divisors.
module tb_uart_transmitter;

   localparam int C0 = 4;
   localparam int C1 = 104;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, valid_a, ready_a, tx_a, busy_a, done_a;
   logic [7:0] data_a;
   logic       rst_b, valid_b, ready_b, tx_b, busy_b, done_b;
   logic [7:0] data_b;

   uart_transmitter #(.CLKS_PER_BIT(C0)) dut (
      .i_clk(clk), .i_rst(rst_a), .i_data(data_a), .i_valid(valid_a),
      .o_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
   );

   uart_transmitter #(.CLKS_PER_BIT(C1)) dut_l (
      .i_clk(clk), .i_rst(rst_b), .i_data(data_b), .i_valid(valid_b),
      .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int nd_a = 0;
   int nd_b = 0;
   bit live = 1'b0;

   // model: per instance, frame in flight + queued bytes
   int         cpb [2] = '{C0, C1};
   bit         mbusy [2];
   int         mpos [2];
   int         mcnt [2];
   logic [7:0] mq [2][2];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_tx(input int i);
      int b;
      if (!mbusy[i]) return 1'b1;
      b = mpos[i] / cpb[i];
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return mq[i][0][b-1];
   endfunction

   function automatic logic exp_ready(input int i, input logic r);
      return !r && !(mbusy[i] && mcnt[i] == 2);
   endfunction

   function automatic logic exp_done(input int i);
      return mbusy[i] && (mpos[i] == 10 * cpb[i] - 1);
   endfunction

   task automatic upd(input int i, input logic r, input logic v,
                      input logic [7:0] d);
      bit acc;
      acc = v && exp_ready(i, r);
      if (r) begin
         mbusy[i] = 1'b0;
         mcnt[i]  = 0;
         mpos[i]  = 0;
      end else if (mbusy[i]) begin
         if (mpos[i] == 10 * cpb[i] - 1) begin
            mq[i][0] = mq[i][1];
            mcnt[i]--;
            if (acc) begin
               mq[i][mcnt[i]] = d;
               mcnt[i]++;
            end
            mpos[i]  = 0;
            mbusy[i] = (mcnt[i] > 0);
         end else begin
            mpos[i]++;
            if (acc) begin
               mq[i][mcnt[i]] = d;
               mcnt[i]++;
            end
         end
      end else if (acc) begin
         mq[i][0] = d;
         mcnt[i]  = 1;
         mpos[i]  = 0;
         mbusy[i] = 1'b1;
      end
   endtask

   task automatic tick(input logic ra, input logic va, input logic [7:0] da,
                       input logic rb, input logic vb, input logic [7:0] db);
      rst_a = ra; valid_a = va; data_a = da;
      rst_b = rb; valid_b = vb; data_b = db;
      #1;
      if (live) begin
         check("tx_a", 32'(tx_a), 32'(exp_tx(0)));
         check("busy_a", 32'(busy_a), 32'(mbusy[0]));
         check("done_a", 32'(done_a), 32'(exp_done(0)));
         check("ready_a", 32'(ready_a), 32'(exp_ready(0, ra)));
         check("tx_b", 32'(tx_b), 32'(exp_tx(1)));
         check("busy_b", 32'(busy_b), 32'(mbusy[1]));
         check("done_b", 32'(done_b), 32'(exp_done(1)));
         check("ready_b", 32'(ready_b), 32'(exp_ready(1, rb)));
      end
      if (done_a === 1'b1) nd_a++;
      if (done_b === 1'b1) nd_b++;
      @(posedge clk);
      upd(0, ra, va, da);
      upd(1, rb, vb, db);
      cyc++;
      @(negedge clk);
   endtask

   task automatic ta(input logic r, input logic v, input logic [7:0] d);
      tick(r, v, d, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic idle(input int n);
      repeat (n) ta(1'b0, 1'b0, 8'($urandom));
   endtask

   initial begin
      logic [7:0] bp [3];
      int k, t1, t3, guard, n0;
      for (int i = 0; i < 2; i++) begin
         mbusy[i] = 1'b0; mpos[i] = 0; mcnt[i] = 0;
      end
      rst_a = 1'b1; valid_a = 1'b0; data_a = 8'h00;
      rst_b = 1'b1; valid_b = 1'b0; data_b = 8'h00;
      @(negedge clk);
      tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
      live = 1'b1;
      tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
      idle(3);

      // single byte
      n0 = nd_a;
      ta(1'b0, 1'b1, 8'h55);
      idle(45);
      check("single_frames", 32'(nd_a - n0), 32'd1);

      // back-to-back
      n0 = nd_a;
      ta(1'b0, 1'b1, 8'hA5);
      ta(1'b0, 1'b1, 8'h3C);
      idle(85);
      check("b2b_frames", 32'(nd_a - n0), 32'd2);

      // backpressure with valid held high
      bp[0] = 8'h01; bp[1] = 8'h02; bp[2] = 8'h03;
      k = 0; t1 = 0; t3 = 0; guard = 0; n0 = nd_a;
      while (k < 3 && guard < 200) begin
         if (exp_ready(0, 1'b0)) begin
            if (k == 0) t1 = cyc;
            if (k == 2) t3 = cyc;
            ta(1'b0, 1'b1, bp[k]);
            k++;
         end else begin
            ta(1'b0, 1'b1, bp[k]);
         end
         guard++;
      end
      check("bp_accepts", 32'(k), 32'd3);
      check("bp_third_at", 32'(t3 - t1), 32'd41);
      idle(130);
      check("bp_frames", 32'(nd_a - n0), 32'd3);

      // reset during data bit 3 with a byte held
      ta(1'b0, 1'b1, 8'hFF);
      ta(1'b0, 1'b1, 8'h11);
      idle(16);
      ta(1'b1, 1'b0, 8'h00);
      n0 = nd_a;
      idle(60);
      check("rst_no_frame", 32'(nd_a - n0), 32'd0);
      ta(1'b0, 1'b1, 8'h81);
      idle(45);
      check("rst_new_frame", 32'(nd_a - n0), 32'd1);

      // accept exactly on the done cycle, buffer empty
      n0 = nd_a;
      ta(1'b0, 1'b1, 8'h12);
      idle(39);
      ta(1'b0, 1'b1, 8'h7E);
      idle(45);
      check("edge_frames", 32'(nd_a - n0), 32'd2);

      // random traffic with occasional reset
      for (int i = 0; i < 300; i++) begin
         ta(logic'($urandom_range(63) == 0), logic'($urandom_range(1)),
            8'($urandom));
      end
      idle(90);

      // large divisor
      n0 = nd_b;
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC3);
      repeat (1045) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'($urandom));
      check("big_frames", 32'(nd_b - n0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
